// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the hazard controller: FSM states, forward-select codes, scoreboard entry.
// Pure declarations: no latency, no flow control.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        LSTALL = 2'b01,
        FLUSH  = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // The key is the part a source register is compared against; mem_to_reg only matters at EX.
    typedef struct packed {
        logic       valid;
        logic       reg_wr;
        logic [4:0] rw;
    } sb_key_t;

    typedef struct packed {
        sb_key_t key;
        logic    mem_to_reg;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end
        if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hz_match.sv
// Compares one source register against one scoreboard entry; $0 never matches.
// Combinational, zero latency, no flow control.
module hz_match
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  sb_key_t    ent_i,
    output logic       match_o
);

    assign match_o = ent_i.valid & ent_i.reg_wr & (ent_i.rw == src_i) & (src_i != 5'd0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: EX/MEM/WR scoreboard, forwarding selects, load-use stall and branch flush FSM.
// Outputs are combinational from state and ID inputs; HAZARD_PERF_CNT_EN adds stall/flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_reg_wr,
    input  logic [4:0]  id_rw,
    input  logic        id_mem_to_reg,
    input  logic        ex_br_taken,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_bubble,
    output logic        ifid_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  hz_state
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    sb_entry_t ex_q, ex_d, mem_q, mem_d, wr_q, wr_d;
    hz_state_e state_q, state_d;
    sb_key_t   keys [3];
    logic [2:0] hit_rs, hit_rt;
    logic       load_use;

    assign keys[0] = ex_q.key;
    assign keys[1] = mem_q.key;
    assign keys[2] = wr_q.key;

    for (genvar i = 0; i < 3; i++) begin : g_match
        hz_match u_rs (.src_i(id_rs), .ent_i(keys[i]), .match_o(hit_rs[i]));
        hz_match u_rt (.src_i(id_rt), .ent_i(keys[i]), .match_o(hit_rt[i]));
    end

    assign load_use = id_valid & ex_q.mem_to_reg & (hit_rs[0] | (id_uses_rt & hit_rt[0]));
    assign fwd_a    = fwd_sel(hit_rs[1], hit_rs[2]);
    assign fwd_b    = id_uses_rt ? fwd_sel(hit_rt[1], hit_rt[2]) : FWD_RF;
    assign hz_state = state_q;

    always_comb begin
        ex_d = SB_EMPTY;
        if (!idex_bubble) begin
            ex_d.key.valid  = id_valid;
            ex_d.key.reg_wr = id_reg_wr;
            ex_d.key.rw     = id_rw;
            ex_d.mem_to_reg = id_mem_to_reg;
        end
        mem_d = ex_q;
        wr_d  = mem_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q    <= SB_EMPTY;
            mem_q   <= SB_EMPTY;
            wr_q    <= SB_EMPTY;
            state_q <= RUN;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = RUN;
        case (state_q)
            RUN: begin
                if (ex_br_taken) begin
                    state_d = FLUSH;
                end else if (load_use) begin
                    state_d = LSTALL;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Stall and flush are raised on the cycle that enters LSTALL/FLUSH; those states are the idle
    // recovery cycle, during which any hazard seen in ID is stale and ignored.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (rst_n && state_q == RUN) begin
            if (ex_br_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (state_d == LSTALL && stall_cnt_q != 16'hFFFF) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (state_d == FLUSH && flush_cnt_q != 16'hFFFF) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: instruction-history model checked every cycle, plus literal spot checks.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rt, id_reg_wr, id_mem_to_reg, ex_br_taken;
    logic [4:0] id_rs, id_rt, id_rw;
    logic       pc_stall, ifid_stall, idex_bubble, ifid_flush;
    logic [1:0] fwd_a, fwd_b, hz_state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    pipe_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_reg_wr(id_reg_wr), .id_rw(id_rw),
        .id_mem_to_reg(id_mem_to_reg), .ex_br_taken(ex_br_taken),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .hz_state(hz_state)
`ifdef HAZARD_PERF_CNT_EN
       ,.stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Model: the last three instructions issued past ID, newest first (0=EX, 1=MEM, 2=WR),
    // and how the previous cycle ended (0 normal, 1 after a load stall, 2 after a branch flush).
    typedef struct { bit v; bit wr; int rw; bit ld; } ment_t;
    ment_t hist [3];
    ment_t nxt_hist [3];
    int    m_after = 0;
    int    nxt_after = 0;
    bit    started = 0;

    function automatic bit produces(int d, int src);
        return hist[d].v && hist[d].wr && hist[d].rw == src && src != 0;
    endfunction

    function automatic int fwd_of(int src);
        for (int d = 1; d <= 2; d++)
            if (produces(d, src)) return d;
        return 0;
    endfunction

    function automatic logic [15:0] outs_vec(bit st, bit bub, bit fl, int fa, int fb, int hs);
        logic [15:0] v;
        v = '0;
        v[9] = st; v[8] = st; v[7] = bub; v[6] = fl;
        v[5:4] = 2'(fa); v[3:2] = 2'(fb); v[1:0] = 2'(hs);
        return v;
    endfunction

    function automatic logic [15:0] dut_vec();
        return {6'd0, pc_stall, ifid_stall, idex_bubble, ifid_flush, fwd_a, fwd_b, hz_state};
    endfunction

    always @(negedge clk) begin
        if (started) begin
            bit lu, st, fl, bub;
            int fb;
            lu  = id_valid && hist[0].ld &&
                  (produces(0, int'(id_rs)) || (id_uses_rt && produces(0, int'(id_rt))));
            st  = 0; fl = 0; bub = 0;
            nxt_after = 0;
            if (m_after == 0 && ex_br_taken) begin
                fl = 1; bub = 1; nxt_after = 2;
            end else if (m_after == 0 && lu) begin
                st = 1; bub = 1; nxt_after = 1;
            end
            if (!rst_n) begin
                st = 0; fl = 0; bub = 0;
            end
            fb = id_uses_rt ? fwd_of(int'(id_rt)) : 0;
            check("cycle", dut_vec(), outs_vec(st, bub, fl, fwd_of(int'(id_rs)), fb, m_after));
            nxt_hist[2] = hist[1];
            nxt_hist[1] = hist[0];
            if (bub) nxt_hist[0] = '{0, 0, 0, 0};
            else     nxt_hist[0] = '{id_valid, id_reg_wr, int'(id_rw), id_mem_to_reg};
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0};
            m_after = 0;
        end else if (started) begin
            hist    = nxt_hist;
            m_after = nxt_after;
        end
        started = 1;
    end

    task automatic issue(input bit v, input int rs, input int rt, input bit ur, input bit wr,
                         input int rw, input bit ld, input bit br);
        @(posedge clk); #1;
        id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = ur;
        id_reg_wr = wr; id_rw = 5'(rw); id_mem_to_reg = ld; ex_br_taken = br;
        @(negedge clk); #1;
    endtask

    task automatic nop(); issue(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic alu(input int rs, input int rt, input int rw); issue(1, rs, rt, 1, 1, rw, 0, 0); endtask
    task automatic lw(input int base, input int rw); issue(1, base, 0, 0, 1, rw, 1, 0); endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; id_reg_wr = 0;
        id_rw = 0; id_mem_to_reg = 0; ex_br_taken = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset_outs", dut_vec(), 16'h0000);
        @(posedge clk); #1; rst_n = 1'b1;

        // add $3,$1,$2 ; independent ; sub $4,$3,$5 ; then $3 read from WR
        alu(1, 2, 3); alu(6, 7, 11); alu(3, 5, 4);
        check("raw_mem_fwd_a", 16'(fwd_a), 16'h1);
        check("raw_mem_fwd_b", 16'(fwd_b), 16'h0);
        check("raw_no_stall", 16'(pc_stall), 16'h0);
        alu(3, 0, 12);
        check("raw_wb_fwd_a", 16'(fwd_a), 16'h2);
        repeat (3) nop();

        // lw $8 ; add $10,$8,$8 (stall one cycle) ; back-to-back with lw $11 ; add $12,$11,$0
        lw(9, 8); alu(8, 8, 10);
        check("lu_stall", {13'd0, pc_stall, ifid_stall, idex_bubble}, 16'h7);
        check("lu_state_run", 16'(hz_state), 16'h0);
        alu(8, 8, 10);
        check("lu_state_lstall", 16'(hz_state), 16'h1);
        check("lu_released", {13'd0, pc_stall, ifid_stall, idex_bubble}, 16'h0);
        check("lu_fwd_ab", {12'd0, fwd_a, fwd_b}, 16'h5);
        lw(9, 11); alu(11, 0, 12);
        check("b2b_stall", 16'(pc_stall), 16'h1);
        alu(11, 0, 12);
        check("b2b_one_cycle", {14'd0, pc_stall, hz_state == 2'b01}, 16'h1);
        repeat (3) nop();

        // branch taken coincides with a load-use hazard
        lw(9, 8); issue(1, 8, 8, 1, 1, 10, 0, 1);
        check("br_flush_bub", {14'd0, ifid_flush, idex_bubble}, 16'h3);
        check("br_no_stall", {14'd0, pc_stall, ifid_stall}, 16'h0);
        nop();
        check("br_state_flush", 16'(hz_state), 16'h2);
        check("br_flush_idle", {12'd0, pc_stall, ifid_stall, idex_bubble, ifid_flush}, 16'h0);
        nop();
        check("br_state_run", 16'(hz_state), 16'h0);
        repeat (2) nop();

        // $0 never forwards and never stalls
        alu(1, 2, 0); alu(6, 7, 11); alu(0, 0, 5);
        check("r0_fwd", {12'd0, fwd_a, fwd_b}, 16'h0);
        lw(9, 0); alu(0, 0, 13);
        check("r0_no_stall", 16'(pc_stall), 16'h0);
        repeat (3) nop();

        // two writers of $7: the newer one (MEM) wins
        alu(1, 2, 7); alu(3, 4, 7); nop(); alu(7, 7, 14);
        check("newest_wins", {12'd0, fwd_a, fwd_b}, 16'h5);
        // rt field matches the load but is not read
        lw(9, 8); issue(1, 1, 8, 0, 1, 10, 0, 0);
        check("rt_unused_no_stall", {14'd0, pc_stall, fwd_b != 2'b00}, 16'h0);
        repeat (3) nop();

        // reset asserted while in LSTALL
        lw(9, 8); alu(8, 8, 10);
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); #1;
        check("rst_mid_lstall", dut_vec(), 16'h0000);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk); #1;
        check("rst_no_residual", dut_vec(), 16'h0000);
        repeat (2) nop();

`ifdef HAZARD_PERF_CNT_EN
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk); #1;
        check("cnt_reset", stall_cnt | flush_cnt, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            issue(0, 0, 0, 0, 0, 0, 0, 1);
            nop();
        end
        @(negedge clk); #1;
        check("flush_cnt", flush_cnt, 16'd5);
        // self-dependent load held in ID: one stall every two cycles
        issue(1, 8, 0, 0, 1, 8, 1, 0);
        repeat (140004) @(posedge clk);
        @(negedge clk); #1;
        check("stall_cnt_sat", stall_cnt, 16'hFFFF);
        check("flush_cnt_hold", flush_cnt, 16'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
